// File: rtl/branch_predictor_bht_pkg.sv
// Shared decode constants and counter reset value for the branch history table.
package branch_predictor_bht_pkg;

    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;

    // Weakly taken: only the MSB of a cnt_bits-wide counter is set.
    function automatic logic [2:0] cnt_reset_val(input int cnt_bits);
        return 3'(1) << (cnt_bits - 1);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter_update.sv
// Combinational next-state of one saturating up/down counter.
module sat_counter_update #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] cnt,
    input  logic                taken,
    output logic [CNT_BITS-1:0] cnt_next
);

    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != '1) cnt_next = cnt + CNT_BITS'(1);
        end else begin
            if (cnt != '0) cnt_next = cnt - CNT_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic direction predictor for the IF stage: bimodal or gshare counter table,
// combinational lookup, trained by resolved branch outcomes from EX.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int size      = 32,
    parameter int ENTRIES   = 64,
    parameter int CNT_BITS  = 2,
    parameter int GSHARE    = 0,
    parameter int HIST_BITS = 6
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [size-1:0]            instruction,
    input  logic [size-1:0]            pc,
    input  logic [size-1:0]            IMM,
    input  logic                       isValid,
    output logic                       Predicted_MPC,
    output logic [size-1:0]            pred_target,
    output logic                       JALR,
    output logic [$clog2(ENTRIES)-1:0] pred_index,
    input  logic                       upd_valid,
    input  logic [$clog2(ENTRIES)-1:0] upd_index,
    input  logic                       upd_taken
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [CNT_BITS-1:0] CNT_RST = CNT_BITS'(cnt_reset_val(CNT_BITS));

    logic [CNT_BITS-1:0] cnt_reg [ENTRIES];
    logic [CNT_BITS-1:0] upd_cnt_next;
    logic [IDX-1:0]      pc_index;
    logic [IDX-1:0]      lookup_index;
    logic [4:0]          opcode;
    logic                is_jal, is_branch, is_jalr;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^{instruction[size-1:7], instruction[1:0]};

    assign opcode    = instruction[6:2];
    assign is_jal    = (opcode == OP_JAL);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jalr   = (opcode == OP_JALR);
    assign pc_index  = pc[IDX+1:2];

    sat_counter_update #(.CNT_BITS(CNT_BITS)) u_sat_counter_update (
        .cnt      (cnt_reg[upd_index]),
        .taken    (upd_taken),
        .cnt_next (upd_cnt_next)
    );

    // Reset wins over a coincident update, so no training survives a reset edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) cnt_reg[i] <= CNT_RST;
        end else if (upd_valid) begin
            cnt_reg[upd_index] <= upd_cnt_next;
        end
    end

    generate
        if (GSHARE != 0) begin : g_gshare
            logic [HIST_BITS-1:0] ghr_reg;
            logic [HIST_BITS-1:0] ghr_next;

            // History is shifted at resolution time, never speculatively at fetch.
            if (HIST_BITS == 1) begin : g_hist1
                assign ghr_next = upd_taken;
            end else begin : g_histn
                assign ghr_next = {ghr_reg[HIST_BITS-2:0], upd_taken};
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ghr_reg <= '0;
                end else if (upd_valid) begin
                    ghr_reg <= ghr_next;
                end
            end

            assign lookup_index = pc_index ^ IDX'(ghr_reg);
        end else begin : g_bimodal
            assign lookup_index = pc_index;
        end
    endgenerate

    assign pred_index    = lookup_index;
    assign pred_target   = pc + IMM;
    assign JALR          = isValid & is_jalr;
    assign Predicted_MPC = isValid & (is_jal | (is_branch & cnt_reg[lookup_index][CNT_BITS-1]));

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Randomised and directed checks of a bimodal and a gshare predictor against a table model.
module tb_branch_predictor_bht;

    localparam int ENTRIES = 64;
    localparam int IDX     = 6;
    localparam logic [4:0] J_OP  = 5'b11011;
    localparam logic [4:0] B_OP  = 5'b11000;
    localparam logic [4:0] JR_OP = 5'b11001;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     instruction, pc, IMM;
    logic            isValid, upd_valid, upd_taken;
    logic [IDX-1:0]  upd_index;
    logic            bi_mpc, gs_mpc, bi_jalr, gs_jalr;
    logic [31:0]     bi_target, gs_target;
    logic [IDX-1:0]  bi_index, gs_index;

    int checks = 0;
    int failures = 0;
    int cnt_bi [ENTRIES];
    int cnt_gs [ENTRIES];
    int ghr;

    always #5 clk = ~clk;

    branch_predictor_bht #(.size(32), .ENTRIES(ENTRIES), .CNT_BITS(2), .GSHARE(0), .HIST_BITS(6)) dut_bi (
        .clk(clk), .reset(reset), .instruction(instruction), .pc(pc), .IMM(IMM),
        .isValid(isValid), .Predicted_MPC(bi_mpc), .pred_target(bi_target), .JALR(bi_jalr),
        .pred_index(bi_index), .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken)
    );

    branch_predictor_bht #(.size(32), .ENTRIES(ENTRIES), .CNT_BITS(2), .GSHARE(1), .HIST_BITS(4)) dut_gs (
        .clk(clk), .reset(reset), .instruction(instruction), .pc(pc), .IMM(IMM),
        .isValid(isValid), .Predicted_MPC(gs_mpc), .pred_target(gs_target), .JALR(gs_jalr),
        .pred_index(gs_index), .upd_valid(upd_valid), .upd_index(upd_index), .upd_taken(upd_taken)
    );

    // ---- reference model: integer counters 0..3, 4-bit history as an int ----
    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            cnt_bi[i] = 2;
            cnt_gs[i] = 2;
        end
        ghr = 0;
    endtask

    task automatic model_update(input int idx, input bit taken);
        if (taken) begin
            if (cnt_bi[idx] < 3) cnt_bi[idx] = cnt_bi[idx] + 1;
            if (cnt_gs[idx] < 3) cnt_gs[idx] = cnt_gs[idx] + 1;
        end else begin
            if (cnt_bi[idx] > 0) cnt_bi[idx] = cnt_bi[idx] - 1;
            if (cnt_gs[idx] > 0) cnt_gs[idx] = cnt_gs[idx] - 1;
        end
        ghr = (ghr * 2 + int'(taken)) % 16;
    endtask

    function automatic int bi_idx_of(input logic [31:0] p);
        return int'((p / 4) % ENTRIES);
    endfunction

    function automatic int gs_idx_of(input logic [31:0] p);
        return bi_idx_of(p) ^ ghr;
    endfunction

    function automatic logic mpc_of(input logic v, input logic [31:0] ins, input int c);
        logic [4:0] op;
        op = ins[6:2];
        if (!v) return 1'b0;
        if (op == J_OP) return 1'b1;
        if (op == B_OP) return (c >= 2);
        return 1'b0;
    endfunction

    function automatic logic [31:0] mk_instr(input logic [4:0] op);
        logic [31:0] r;
        r = $urandom;
        r[6:2] = op;
        return r;
    endfunction

    task automatic set_lookup(input logic v, input logic [4:0] op, input logic [31:0] p);
        isValid     = v;
        instruction = mk_instr(op);
        pc          = p;
        IMM         = $urandom;
        #1;
    endtask

    // One update through a clock edge; the model follows unless reset holds.
    task automatic pulse_update(input int idx, input bit taken);
        upd_valid = 1'b1;
        upd_index = IDX'(idx);
        upd_taken = taken;
        @(posedge clk);
        if (!reset) model_update(idx, taken);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
        set_lookup(1'b1, B_OP, 32'h40);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL reset_mpc got=%b exp=1", bi_mpc); end
        checks++; if (bi_index !== 6'd16) begin failures++; $display("FAIL reset_index got=%0d exp=16", bi_index); end
        checks++; if (gs_index !== 6'd16) begin failures++; $display("FAIL reset_gs_index got=%0d exp=16", gs_index); end
        checks++; if (bi_target !== 32'h40 + IMM) begin failures++; $display("FAIL reset_target got=%h exp=%h", bi_target, 32'h40 + IMM); end
        $display("test_reset: mpc=%b index=%0d target=%h", bi_mpc, bi_index, bi_target);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_saturation();
        set_lookup(1'b1, B_OP, 32'h40);
        pulse_update(16, 1'b0);
        pulse_update(16, 1'b0);
        #1;
        checks++; if (bi_mpc !== 1'b0) begin failures++; $display("FAIL sat_two_nt got=%b exp=0", bi_mpc); end
        pulse_update(16, 1'b0);
        pulse_update(16, 1'b1);
        #1;
        checks++; if (bi_mpc !== 1'b0) begin failures++; $display("FAIL sat_floor got=%b exp=0", bi_mpc); end
        pulse_update(16, 1'b1);
        #1;
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL sat_restore got=%b exp=1", bi_mpc); end
        pulse_update(16, 1'b1);
        pulse_update(16, 1'b1);
        pulse_update(16, 1'b0);
        #1;
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL sat_ceiling got=%b exp=1", bi_mpc); end
        $display("test_saturation: counter16 model=%0d mpc=%b", cnt_bi[16], bi_mpc);
    endtask

    task automatic test_read_before_write();
        set_lookup(1'b1, B_OP, 32'h40);
        upd_valid = 1'b1; upd_index = 6'd16; upd_taken = 1'b0;
        #1;
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL rbw_same_cycle got=%b exp=1", bi_mpc); end
        @(posedge clk);
        model_update(16, 1'b0);
        #1;
        upd_valid = 1'b0;
        #1;
        checks++; if (bi_mpc !== 1'b0) begin failures++; $display("FAIL rbw_next_cycle got=%b exp=0", bi_mpc); end
        $display("test_read_before_write: after update mpc=%b", bi_mpc);
    endtask

    task automatic test_decode();
        logic [4:0] ops [3];
        ops[0] = J_OP; ops[1] = B_OP; ops[2] = JR_OP;
        pulse_update(16, 1'b0);
        set_lookup(1'b1, J_OP, 32'h40);
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL jal_taken got=%b exp=1", bi_mpc); end
        checks++; if (bi_jalr !== 1'b0) begin failures++; $display("FAIL jal_not_jalr got=%b exp=0", bi_jalr); end
        set_lookup(1'b1, JR_OP, 32'h40);
        checks++; if (bi_jalr !== 1'b1) begin failures++; $display("FAIL jalr_flag got=%b exp=1", bi_jalr); end
        checks++; if (bi_mpc !== 1'b0) begin failures++; $display("FAIL jalr_mpc got=%b exp=0", bi_mpc); end
        for (int k = 0; k < 3; k++) begin
            set_lookup(1'b0, ops[k], 32'h40);
            checks++; if ({bi_mpc, bi_jalr} !== 2'b00) begin failures++; $display("FAIL invalid_op%0d got=%b%b exp=00", k, bi_mpc, bi_jalr); end
        end
        $display("test_decode: done");
    endtask

    task automatic test_gshare();
        apply_reset();
        pulse_update(5, 1'b1);
        pulse_update(6, 1'b0);
        pulse_update(7, 1'b1);
        pulse_update(8, 1'b1);
        set_lookup(1'b1, B_OP, 32'h40);
        checks++; if (gs_index !== 6'd27) begin failures++; $display("FAIL gshare_index got=%0d exp=27", gs_index); end
        checks++; if (bi_index !== 6'd16) begin failures++; $display("FAIL gshare_bi_index got=%0d exp=16", bi_index); end
        checks++; if (gs_mpc !== mpc_of(1'b1, instruction, cnt_gs[27])) begin failures++; $display("FAIL gshare_mpc got=%b exp=%b", gs_mpc, mpc_of(1'b1, instruction, cnt_gs[27])); end
        $display("test_gshare: ghr model=%0d gs_index=%0d", ghr, gs_index);
    endtask

    task automatic test_random();
        logic [4:0] op;
        int         sel;
        logic       e_bm, e_gm, e_jr;
        int         e_bi, e_gi;
        for (int it = 0; it < 300; it++) begin
            sel = $urandom_range(0, 3);
            op  = (sel == 0) ? J_OP : (sel == 1) ? B_OP : (sel == 2) ? JR_OP : 5'($urandom);
            set_lookup($urandom_range(0, 3) != 0, op, $urandom);
            upd_valid = $urandom_range(0, 1);
            upd_index = IDX'($urandom);
            upd_taken = $urandom_range(0, 1);
            #1;
            e_bi = bi_idx_of(pc);
            e_gi = gs_idx_of(pc);
            e_bm = mpc_of(isValid, instruction, cnt_bi[e_bi]);
            e_gm = mpc_of(isValid, instruction, cnt_gs[e_gi]);
            e_jr = isValid && (instruction[6:2] == JR_OP);
            checks++; if (bi_mpc !== e_bm) begin failures++; $display("FAIL rnd%0d_bi_mpc got=%b exp=%b", it, bi_mpc, e_bm); end
            checks++; if (gs_mpc !== e_gm) begin failures++; $display("FAIL rnd%0d_gs_mpc got=%b exp=%b", it, gs_mpc, e_gm); end
            checks++; if (int'(bi_index) != e_bi) begin failures++; $display("FAIL rnd%0d_bi_index got=%0d exp=%0d", it, bi_index, e_bi); end
            checks++; if (int'(gs_index) != e_gi) begin failures++; $display("FAIL rnd%0d_gs_index got=%0d exp=%0d", it, gs_index, e_gi); end
            checks++; if ({bi_jalr, gs_jalr} !== {e_jr, e_jr}) begin failures++; $display("FAIL rnd%0d_jalr got=%b%b exp=%b", it, bi_jalr, gs_jalr, e_jr); end
            checks++; if (gs_target !== pc + IMM) begin failures++; $display("FAIL rnd%0d_target got=%h exp=%h", it, gs_target, pc + IMM); end
            $display("rnd %0d: v=%b op=%b idx=%0d/%0d mpc=%b/%b upd=%b@%0d:%b",
                     it, isValid, instruction[6:2], bi_index, gs_index, bi_mpc, gs_mpc, upd_valid, upd_index, upd_taken);
            @(posedge clk);
            if (upd_valid) model_update(int'(upd_index), upd_taken);
            #1;
        end
        upd_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        pulse_update(16, 1'b0);
        pulse_update(16, 1'b0);
        set_lookup(1'b1, B_OP, 32'h40);
        checks++; if (bi_mpc !== 1'b0) begin failures++; $display("FAIL mid_pretrain got=%b exp=0", bi_mpc); end
        upd_valid = 1'b1; upd_index = 6'd16; upd_taken = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL mid_async_counter got=%b exp=1", bi_mpc); end
        checks++; if (gs_index !== 6'd16) begin failures++; $display("FAIL mid_async_ghr got=%0d exp=16", gs_index); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        upd_valid = 1'b0;
        model_reset();
        #1;
        checks++; if (bi_mpc !== 1'b1) begin failures++; $display("FAIL mid_update_dropped got=%b exp=1", bi_mpc); end
        checks++; if (gs_index !== 6'd16) begin failures++; $display("FAIL mid_ghr_after got=%0d exp=16", gs_index); end
        $display("test_reset_mid: mpc=%b gs_index=%0d", bi_mpc, gs_index);
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_read_before_write();
        test_decode();
        test_gshare();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Dynamic branch predictor replacing the static always-taken scheme in the IF stage of the 5-stage RV32I pipeline. Holds a table of saturating counters indexed by PC (optionally XORed with a global history register, gshare mode), predicts direction for conditional branches combinationally, and trains on resolved outcomes returned from EX. JAL is always predicted taken; JALR is flagged for the existing redirect path.

## Interface
- `size`, 32: datapath width.
- `ENTRIES`, 64: counter table depth; power of two, 4..1024.
- `CNT_BITS`, 2: counter width, 1..3.
- `GSHARE`, 0: 0 = bimodal (PC index), 1 = gshare (PC XOR history).
- `HIST_BITS`, 6: global history length, ≤ log2(`ENTRIES`); unused when `GSHARE`=0.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `instruction` in `size`: fetched instruction.
- `pc` in `size`: PC of `instruction`.
- `IMM` in `size`: decoded B/J immediate.
- `isValid` in 1: fetch slot holds a real instruction.
- `Predicted_MPC` out 1: predict redirect (taken).
- `pred_target` out `size`: `pc + IMM`.
- `JALR` out 1: instruction is JALR.
- `pred_index` out log2(`ENTRIES`): table index used; carried down the pipe to EX.
- `upd_valid` in 1: EX resolved a conditional branch this cycle.
- `upd_index` in log2(`ENTRIES`): `pred_index` carried with that branch.
- `upd_taken` in 1: actual outcome.

## Operation
- Decode from `instruction[6:2]`: J = 11011, B = 11000, JALR = 11001.
- IDX = log2(`ENTRIES`). Bimodal index = `pc[IDX+1:2]`. Gshare index = `pc[IDX+1:2]` XOR {zeros, `ghr`}.
- `Predicted_MPC` = `isValid` & (J | (B & `cnt[index][CNT_BITS-1]`)).
- `JALR` = `isValid` & JALR decode.
- `pred_target` = `pc + IMM`, modulo 2^`size`, always driven.
- Update at the clock edge when `upd_valid`=1: `cnt[upd_index]` += 1 if `upd_taken` (saturating at all-ones), else -= 1 (saturating at 0). Other entries are unchanged.
- GHR (gshare only): on `upd_valid`, `ghr` <= {`ghr[HIST_BITS-2:0]`, `upd_taken`}. The GHR is updated at resolution, not speculatively.
- Reset: every counter is set to weakly taken (MSB=1, others 0; 2'b10 for 2 bits) and `ghr` is set to 0. Reset takes effect immediately regardless of in-flight updates. An update coinciding with reset is dropped.

## Timing
- Lookup is purely combinational: `Predicted_MPC`, `pred_target`, `JALR`, and `pred_index` settle within the cycle from `instruction`, `pc`, and `IMM`.
- Update latency is 1 cycle: the new counter value is visible to lookups from the cycle after the `upd_valid` edge.
- Simultaneous lookup and update on the same index: the lookup sees the pre-update value (read-before-write). There is no bypass.
- GHR shift and counter write occur on the same edge.
- Outputs during reset: `Predicted_MPC`=1 only for valid J/B instructions (weakly-taken table). `JALR` follows decode. `pred_index` follows the bimodal/gshare index with `ghr`=0.
- `isValid`=0 forces `Predicted_MPC`=0 and `JALR`=0. `pred_index` and `pred_target` remain don't-care but defined.

## Structure
- Shared package: opcode constants (OP_JAL, OP_BRANCH, OP_JALR) and the counter reset constant function of `CNT_BITS`.
- Sub-module `sat_counter_update`: combinational next-state of one counter (`cnt`, `taken` -> `cnt_next`), parametrised by `CNT_BITS`.
- The table is a flop array (`ENTRIES` x `CNT_BITS`) with per-entry async reset. It is not inferred RAM.

## Test plan
- Reset, then a valid B at `pc`=0x40 with `ENTRIES`=64 → `Predicted_MPC`=1, `pred_index`=16, `pred_target`=0x40+`IMM`.
- Two `upd_valid` not-taken updates to index 16, then lookup at 0x40 → `Predicted_MPC`=0. A third not-taken update keeps the counter at 0. Two taken updates restore `Predicted_MPC`=1.
- Same-cycle lookup and update to index 16 from counter 2'b10 with not-taken → `Predicted_MPC`=1 that cycle and 0 the next.
- JAL with counter 0 → `Predicted_MPC`=1. JALR → `JALR`=1, `Predicted_MPC`=0. Any opcode with `isValid`=0 → both 0.
- `GSHARE`=1, `HIST_BITS`=4: updates taken, not, taken, taken → `ghr`=4'b1011. Lookup at `pc`=0x40 → `pred_index`=16^11=27.
- Assert `reset` mid-training: all counters read weakly taken immediately and `ghr`=0. A concurrent `upd_valid` leaves no effect.
